// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line in, read strobe,
// received byte and status flags out.
interface uart_rx_if;
   logic       rx;
   logic       rd_en;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   modport slave (
      input  rx, rd_en,
      output rx_data, rx_ready, overrun, frame_err, busy
   );

   modport master (
      output rx, rd_en,
      input  rx_data, rx_ready, overrun, frame_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection on the start bit,
// a single holding register and ready/overrun/framing-error status.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | line idle, waiting for rx_s low
// S_START     | half a bit into the start bit, confirm it is still low
// S_DATA      | sampling 8 data bits LSB first at mid-bit
// S_STOP      | sampling the stop bit, commit byte or flag framing error
// S_WAIT_IDLE | stop bit was low (break); wait for the line to return high
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic clock,
   input logic reset,
   uart_rx_if.slave bus
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_ready_q, rx_ready_d;
   logic            overrun_q, overrun_d;
   logic            frame_err_q, frame_err_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            rx_s;

   assign rx_s = sync2_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_ready_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_ready_q  <= rx_ready_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_ready_d  = rx_ready_q & ~bus.rd_en;
      overrun_d   = overrun_q & ~bus.rd_en;
      frame_err_d = 1'b0;
      sync1_d     = bus.rx;
      sync2_d     = sync1_q;

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  rx_data_d  = shift_q;
                  rx_ready_d = 1'b1;
                  // a read on the same edge consumes the old byte, so no overrun
                  if (rx_ready_q && !bus.rd_en) overrun_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_ready  = rx_ready_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, with received
// bytes and framing errors checked against a queue of expected line events.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   uart_rx_if bus();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Line model: start bit 0, data LSB first, then the stop bit, each CPB
   // cycles long. A positive cut stops driving early and leaves rx as is.
   task automatic drive_frame(input logic [7:0] d, input bit stop, input int cut);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int c = 0; c < 10 * CPB; c++) begin
         if (cut > 0 && c >= cut) break;
         bus.rx = fr[c / CPB];
         @(negedge clock);
      end
   endtask

   task automatic send_good(input logic [7:0] d);
      exp_q.push_back('{is_err: 1'b0, data: d});
      drive_frame(d, 1'b1, 0);
   endtask

   task automatic pulse_rd();
      bus.rd_en = 1'b1;
      @(negedge clock);
      bus.rd_en = 1'b0;
      @(negedge clock);
   endtask

   // Monitor: every new byte (rx_ready rising) and every framing error must
   // match the oldest expected event.
   logic rdy_prev = 1'b0;
   logic fe_prev  = 1'b0;
   always @(negedge clock) begin : mon
      bit   has_ev;
      exp_t e;
      if (reset) begin
         rdy_prev <= 1'b0;
         fe_prev  <= 1'b0;
      end else begin
         if (bus.frame_err) begin
            has_ev = (exp_q.size() > 0) && exp_q[0].is_err;
            check("frame_err_event_expected", {31'b0, has_ev}, 1);
            check("frame_err_single_cycle", {31'b0, fe_prev}, 0);
            if (has_ev) e = exp_q.pop_front();
         end
         if (bus.rx_ready && !rdy_prev) begin
            has_ev = (exp_q.size() > 0) && !exp_q[0].is_err;
            check("byte_event_expected", {31'b0, has_ev}, 1);
            if (has_ev) begin
               e = exp_q.pop_front();
               check("rx_data", {24'b0, bus.rx_data}, {24'b0, e.data});
            end
         end
         rdy_prev <= bus.rx_ready;
         fe_prev  <= bus.frame_err;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int busy_cnt;
      int seen_rdy;
      int seen_fe;
      int idle_cnt;
      logic [7:0] d;
      bit good;

      bus.rx    = 1'b1;
      bus.rd_en = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clock);
      check("reset_rx_data", {24'b0, bus.rx_data}, 0);
      check("reset_rx_ready", {31'b0, bus.rx_ready}, 0);
      check("reset_overrun", {31'b0, bus.overrun}, 0);
      check("reset_frame_err", {31'b0, bus.frame_err}, 0);
      check("reset_busy", {31'b0, bus.busy}, 0);
      reset = 1'b0;
      @(negedge clock);

      // Single byte: ready appears after the stop-sample edge, 2 sync + HALF + 9 bits in.
      exp_q.push_back('{is_err: 1'b0, data: 8'hC9});
      lat = 0;
      fork
         drive_frame(8'hC9, 1'b1, 0);
         begin
            while (!bus.rx_ready && lat < 400) begin
               @(negedge clock);
               lat++;
            end
         end
      join
      check("t1_ready_latency", lat, 2 + HALF + 9 * CPB + 1);
      check("t1_overrun", {31'b0, bus.overrun}, 0);
      pulse_rd();
      check("t1_ready_cleared", {31'b0, bus.rx_ready}, 0);

      // Back-to-back without a read sets overrun; one read clears both.
      send_good(8'hC9);
      drive_frame(8'h6D, 1'b1, 0);
      check("t2_data", {24'b0, bus.rx_data}, 32'h6D);
      check("t2_ready", {31'b0, bus.rx_ready}, 1);
      check("t2_overrun", {31'b0, bus.overrun}, 1);
      pulse_rd();
      check("t2_ready_cleared", {31'b0, bus.rx_ready}, 0);
      check("t2_overrun_cleared", {31'b0, bus.overrun}, 0);

      // Read coincident with the second stop sample: no overrun.
      send_good(8'hC9);
      fork
         drive_frame(8'h6D, 1'b1, 0);
         begin
            repeat (2 + HALF + 9 * CPB) @(negedge clock);
            bus.rd_en = 1'b1;
            @(negedge clock);
            bus.rd_en = 1'b0;
         end
      join
      check("t2b_data", {24'b0, bus.rx_data}, 32'h6D);
      check("t2b_ready", {31'b0, bus.rx_ready}, 1);
      check("t2b_overrun", {31'b0, bus.overrun}, 0);
      pulse_rd();

      // Glitch of 4 cycles: busy for HALF cycles, no output activity.
      busy_cnt = 0;
      seen_rdy = 0;
      seen_fe  = 0;
      for (int c = 0; c < 30; c++) begin
         bus.rx = (c < 4) ? 1'b0 : 1'b1;
         @(negedge clock);
         if (bus.busy) busy_cnt++;
         if (bus.rx_ready) seen_rdy++;
         if (bus.frame_err) seen_fe++;
      end
      check("t3_busy_cycles", busy_cnt, HALF);
      check("t3_no_ready", seen_rdy, 0);
      check("t3_no_frame_err", seen_fe, 0);
      check("t3_idle_after", {31'b0, bus.busy}, 0);

      // Unread byte, then a framing error must leave it untouched.
      send_good(8'h33);
      exp_q.push_back('{is_err: 1'b1, data: 8'h00});
      drive_frame(8'hA5, 1'b0, 0);
      check("t4_data_kept", {24'b0, bus.rx_data}, 32'h33);
      check("t4_ready_kept", {31'b0, bus.rx_ready}, 1);
      check("t4_no_overrun", {31'b0, bus.overrun}, 0);
      idle_cnt = 0;
      repeat (40 * CPB) begin
         @(negedge clock);
         if (!bus.busy) idle_cnt++;
      end
      check("t4_break_busy", idle_cnt, 0);
      bus.rx = 1'b1;
      lat = 0;
      while (bus.busy && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      check("t4_idle_within_3", {31'b0, (lat <= 3)}, 1);

      // Reset during data bit 4 of 0x3C discards the partial byte.
      drive_frame(8'h3C, 1'b1, 5 * CPB + HALF);
      reset = 1'b1;
      @(negedge clock);
      check("t5_rx_data", {24'b0, bus.rx_data}, 0);
      check("t5_rx_ready", {31'b0, bus.rx_ready}, 0);
      check("t5_overrun", {31'b0, bus.overrun}, 0);
      check("t5_frame_err", {31'b0, bus.frame_err}, 0);
      check("t5_busy", {31'b0, bus.busy}, 0);
      reset  = 1'b0;
      bus.rx = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      check("t5_no_partial", {31'b0, bus.rx_ready}, 0);
      send_good(8'h5A);
      check("t5_ready_after", {31'b0, bus.rx_ready}, 1);
      pulse_rd();

      // Random frames with occasional bad stop bits and random idle gaps.
      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom);
         good = ($urandom_range(0, 9) != 0);
         if (good) begin
            send_good(d);
            check("rand_ready", {31'b0, bus.rx_ready}, 1);
            check("rand_overrun", {31'b0, bus.overrun}, 0);
            pulse_rd();
            check("rand_ready_cleared", {31'b0, bus.rx_ready}, 0);
         end else begin
            exp_q.push_back('{is_err: 1'b1, data: 8'h00});
            drive_frame(d, 1'b0, 0);
         end
         bus.rx = 1'b1;
         repeat ($urandom_range(4, 20)) @(negedge clock);
      end

      repeat (20) @(negedge clock);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1 frames, LSB first. It is the downstream consumer of the TX block's serial line.
- Samples `rx` with a 2-flop synchronizer and checks the start bit at mid-bit, rejecting glitches.
- Captures 8 data bits at mid-bit and checks the stop bit.
- Presents the byte in a single holding register with ready, overrun and framing-error status for the host logic.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal range is 4 or more; HALF = CLKS_PER_BIT/2, rounded down.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx  in  1  serial input; idle high; asynchronous to clock
- rd_en  in  1  host read strobe; clears rx_ready and overrun
- rx_data  out  8  last successfully received byte
- rx_ready  out  1  level; a byte is held and has not yet been read
- overrun  out  1  sticky; a byte completed while rx_ready was already 1
- frame_err  out  1  1-cycle pulse; stop bit sampled as 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- **Reset:** one clock with reset=1 gives:
  - state=IDLE; rx_data=0x00; rx_ready=0; overrun=0; frame_err=0; busy=0.
  - Both synchronizer flops set to 1; bit counter and cycle counter set to 0.
  - Reset overrides everything, including mid-frame; the partial byte is discarded.
- **Synchronizer:** rx_s is rx delayed by 2 flops. All decisions use rx_s only.
- **IDLE:**
  - If rx_s=0 at edge T0: go to START with cnt=0.
  - Otherwise stay in IDLE.
- **START:**
  - cnt increments each cycle.
  - When cnt==HALF-1 (edge T0+HALF), sample rx_s:
    - 0: go to DATA, cnt=0, bit_idx=0.
    - 1: glitch; return to IDLE with no output activity.
- **DATA:**
  - When cnt==CLKS_PER_BIT-1: shift rx_s into bit position bit_idx (LSB first), set cnt=0, bit_idx++.
  - Bit n is sampled at edge T0+HALF+(n+1)*CLKS_PER_BIT.
  - After bit 7, go to STOP.
- **STOP:** sampled when cnt==CLKS_PER_BIT-1, i.e. edge T0+HALF+9*CLKS_PER_BIT.
  - Stop bit = 1:
    - rx_data <= shift register; rx_ready <= 1; go to IDLE.
    - If rx_ready was 1 and rd_en=0 on that edge: overrun <= 1. New data overwrites the old.
  - Stop bit = 0:
    - frame_err=1 for exactly one cycle.
    - rx_data, rx_ready and overrun are unchanged.
    - Go to WAIT_IDLE.
- **WAIT_IDLE:** stay until rx_s=1, then go to IDLE. This prevents a held-low line (break) from being received as repeated 0x00 frames.
- **Host read:**
  - rd_en=1 clears rx_ready and overrun on the next edge.
  - rd_en while rx_ready=0 has no effect.
  - rd_en on the same edge as a successful stop sample: rx_ready stays 1, rx_data takes the new byte, overrun is not set. An already-set overrun is cleared.
- **Status timing:** rx_ready, rx_data and frame_err are registered; they are visible after the stop-sample edge.
- **busy:** combinational from state; it is 0 only in IDLE.
- **Counters:**
  - cnt width is $clog2(CLKS_PER_BIT); bit_idx is 3 bits.
  - cnt clears on every state transition; no wrap-around is exposed.

Test Plan:
1. Single byte with CLKS_PER_BIT=16: drive frame 0xC9 with bits 16 cycles wide.
   - rx_ready rises after edge T0+152 with rx_data=0xC9, frame_err=0, overrun=0.
   - A 1-cycle rd_en then clears rx_ready.
2. Back-to-back 0xC9 then 0x6D, no rd_en.
   - After the second frame: rx_data=0x6D, rx_ready=1, overrun=1.
   - One rd_en clears both flags.
   - Repeat with rd_en coincident with the second stop sample: overrun stays 0.
3. Glitch rejection: pull rx low for 4 cycles, then release.
   - busy pulses for about HALF cycles, then returns to 0; rx_ready=0 and frame_err=0 throughout.
4. Framing error and break:
   - Send 0xA5 with stop=0: frame_err is a single-cycle pulse; rx_data keeps its prior value; rx_ready is unchanged.
   - Hold rx low for 40 more bit times: no further frames and busy stays 1.
   - Raise rx: IDLE within 3 cycles.
5. Reset mid-frame: assert reset for 1 cycle during data bit 4 of 0x3C.
   - All outputs return to reset values; no partial byte appears.
   - The next clean frame 0x5A is received correctly.
6. Loopback with the TX block at a matching bit period, sending 0xC9 then 0x6D with one tx_en pulse each.
   - rx_data equals each byte in order; frame_err is never asserted.
